kbd_mmio_reader: RTL and testbench

- CPU-side receiver for the 64-bit keystroke bus that drives main's keyboard input.
- Detects each new keystroke, queues it in a small FIFO, and exposes it to the core through memory-mapped registers.
- Register map: a DATA register whose read pops the FIFO, and a STATUS register.
- Sits between the keyboard-input pin of main and the core's load/store MMIO decode.

---
 rtl/kbd_pkg.sv | 18 +
 rtl/kbd_fifo.sv | 54 +++++
 rtl/kbd_mmio_reader.sv | 112 +++++++++++
 tb/tb_kbd_mmio_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and types for the keyboard MMIO receiver.
//   - MMIO byte offsets (DATA, IRQ_EN, STATUS)
//   - STATUS register bit positions
//   - kbd_key_t: one keystroke word
package kbd_pkg;

  localparam logic [3:0] KBD_DATA_OFF   = 4'h0;
  localparam logic [3:0] KBD_IRQEN_OFF  = 4'h4;
  localparam logic [3:0] KBD_STATUS_OFF = 4'h8;

  localparam int EMPTY_BIT = 0;
  localparam int OVF_BIT   = 1;
  localparam int FULL_BIT  = 2;
  localparam int CNT_LSB   = 8;

  typedef logic [63:0] kbd_key_t;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous FIFO with first-word-fall-through read port.
// Ports:
//   clk, reset (async, active low)
//   push/wdata : write request, dropped when full unless a pop frees a slot
//   pop        : advance head, ignored when empty
//   rdata      : current head entry (valid when !empty)
//   count/full/empty : occupancy status
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/kbd_mmio_reader.sv
// kbd_mmio_reader: CPU-side receiver for the keystroke bus.
// Captures each new non-zero keystroke into a FIFO and exposes it over MMIO.
// Ports:
//   clk, reset (async, active low)
//   key_in             : current keystroke, 0 = no key held
//   rd_en/rd_addr      : MMIO load; rd_data/rd_valid returned one cycle later
//   wr_en/wr_addr/wr_data : MMIO store
//   irq                : only when KBD_IRQ_EN is defined
// Register map: 0x0 DATA (read pops), 0x4 IRQ_EN (KBD_IRQ_EN only), 0x8 STATUS
//   STATUS = {count @ [8+:CNT_W], full @2, overflow @1, empty @0};
//   writing bit1 of STATUS clears the sticky overflow flag.
// Optional macro: KBD_IRQ_EN adds the irq port and IRQ_EN register.
module kbd_mmio_reader
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KEY_W = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic [63:0]      rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [63:0]      wr_data
`ifdef KBD_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [KEY_W-1:0] key_q;
  logic             key_ev;
  logic             pop, ovf, ovf_set, ovf_clr;
  logic [KEY_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [63:0]      status;

  // New key: value changed and not idle, so a held key fires once.
  assign key_ev  = (key_in != key_q) && (key_in != '0);
  assign pop     = rd_en && (rd_addr == KBD_DATA_OFF) && !empty;
  assign ovf_set = key_ev && full && !pop;
  assign ovf_clr = wr_en && (wr_addr == KBD_STATUS_OFF) && wr_data[OVF_BIT];

  kbd_fifo #(.DEPTH(DEPTH), .W(KEY_W), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_ev),
    .wdata (key_in),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status                   = '0;
    status[EMPTY_BIT]        = empty;
    status[OVF_BIT]          = ovf;
    status[FULL_BIT]         = full;
    status[CNT_LSB +: CNT_W] = count;
  end

`ifdef KBD_IRQ_EN
  logic irq_en;
  logic unused_wr;
  assign unused_wr = ^wr_data[63:2];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_data[63:2], wr_data[0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
`ifdef KBD_IRQ_EN
      irq_en   <= 1'b0;
      irq      <= 1'b0;
`endif
    end else begin
      key_q    <= key_in;
      rd_valid <= rd_en;
      if (rd_en) begin
        case (rd_addr)
          KBD_DATA_OFF:   rd_data <= empty ? 64'd0 : 64'(head);
          KBD_STATUS_OFF: rd_data <= status;
`ifdef KBD_IRQ_EN
          KBD_IRQEN_OFF:  rd_data <= {63'd0, irq_en};
`endif
          default:        rd_data <= '0;
        endcase
      end
      // Set beats clear when both land in the same cycle.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
`ifdef KBD_IRQ_EN
      if (wr_en && (wr_addr == KBD_IRQEN_OFF)) irq_en <= wr_data[0];
      irq <= irq_en & ~empty;
`endif
    end
  end

endmodule

// File: tb/tb_kbd_mmio_reader.sv
// Bench for kbd_mmio_reader: queue-based reference model checked every cycle,
// plus directed sequences with literal expected register values.
module tb_kbd_mmio_reader;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] key_in = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
`ifdef KBD_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kbd_mmio_reader #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
`ifdef KBD_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of keys plus flags, advanced once per clock.
  logic [63:0] mq[$];
  logic [63:0] m_prev = '0;
  bit          m_ovf = 1'b0, m_irqen = 1'b0;
  bit          m_ev, m_pop, m_drop;
  logic [63:0] exp_data = '0;
  bit          exp_valid = 1'b0, exp_irq = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_prev = '0; m_ovf = 1'b0; m_irqen = 1'b0;
      exp_data = '0; exp_valid = 1'b0; exp_irq = 1'b0;
    end else begin
      m_ev  = (key_in != 0) && (key_in != m_prev);
      m_pop = rd_en && (rd_addr == 4'h0) && (mq.size() != 0);
      exp_irq   = m_irqen && (mq.size() != 0);
      exp_valid = rd_en;
      if (rd_en) begin
        if (rd_addr == 4'h0)
          exp_data = (mq.size() != 0) ? mq[0] : 64'd0;
        else if (rd_addr == 4'h8)
          exp_data = (64'(mq.size()) * 256) + ((mq.size() == DEPTH) ? 4 : 0)
                   + (m_ovf ? 2 : 0) + ((mq.size() == 0) ? 1 : 0);
`ifdef KBD_IRQ_EN
        else if (rd_addr == 4'h4)
          exp_data = {63'd0, m_irqen};
`endif
        else
          exp_data = '0;
      end
      if (m_pop) void'(mq.pop_front());
      m_drop = 1'b0;
      if (m_ev) begin
        if (mq.size() < DEPTH) mq.push_back(key_in);
        else m_drop = 1'b1;
      end
      if (wr_en && wr_addr == 4'h8 && wr_data[1]) m_ovf = 1'b0;
      if (m_drop) m_ovf = 1'b1;
`ifdef KBD_IRQ_EN
      if (wr_en && wr_addr == 4'h4) m_irqen = wr_data[0];
`endif
      m_prev = key_in;
    end
  end

  always @(negedge clk) begin
    chk("m_rd_valid", 64'(rd_valid), 64'(exp_valid));
    chk("m_rd_data", rd_data, exp_data);
`ifdef KBD_IRQ_EN
    chk("m_irq", 64'(irq), 64'(exp_irq));
`endif
  end

  task automatic rd(input logic [3:0] a, input logic [63:0] e, input string nm);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk(nm, rd_data, e);
    chk({nm, "_valid"}, 64'(rd_valid), 64'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [63:0] k);
    key_in = k;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Held key gives a single entry
    key_in = 64'h41;
    repeat (10) @(negedge clk);
    push(64'h0);
    rd(4'h8, 64'h100, "t1_status");
    rd(4'h0, 64'h41,  "t1_data");
    rd(4'h8, 64'h1,   "t1_empty");

    // Repeat needs a 0 gap; underflow read returns 0
    push(64'h61); push(64'h62); push(64'h0); push(64'h62); push(64'h63); push(64'h0);
    rd(4'h0, 64'h61, "t2_d0");
    rd(4'h0, 64'h62, "t2_d1");
    rd(4'h0, 64'h62, "t2_d2");
    rd(4'h0, 64'h63, "t2_d3");
    rd(4'h0, 64'h0,  "t2_under");
    rd(4'h8, 64'h1,  "t2_status");

    // Overflow: 9 keys into 8 slots
    for (int i = 0; i < 9; i++) push(64'h71 + 64'(i));
    push(64'h0);
    rd(4'h8, 64'h806, "t3_full");
    for (int i = 0; i < 8; i++) rd(4'h0, 64'h71 + 64'(i), "t3_data");
    rd(4'h8, 64'h3, "t3_ovf_empty");
    wr(4'h8, 64'h2);
    rd(4'h8, 64'h1, "t3_ovf_clr");
    rd(4'h6, 64'h0, "t3_badaddr");

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 8; i++) push(64'h81 + 64'(i));
    key_in = 64'h89;
    rd(4'h0, 64'h81, "t4_pop_push");
    push(64'h0);
    rd(4'h8, 64'h804, "t4_status");
    for (int i = 0; i < 8; i++) rd(4'h0, 64'h82 + 64'(i), "t4_data");
    rd(4'h8, 64'h1, "t4_empty");

    // Asynchronous reset mid-stream with a key held across release
    push(64'hA1); push(64'hA2); push(64'hA3);
    push(64'h55);
    rd(4'h8, 64'h400, "t5_pre");
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_data", rd_data, 64'd0);
    chk("t5_rst_valid", 64'(rd_valid), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    push(64'h0);
    rd(4'h8, 64'h100, "t5_status");
    rd(4'h0, 64'h55,  "t5_data");
    rd(4'h8, 64'h1,   "t5_empty");

`ifdef KBD_IRQ_EN
    wr(4'h4, 64'h1);
    rd(4'h4, 64'h1, "t6_irqen");
    chk("t6_irq_idle", 64'(irq), 64'd0);
    key_in = 64'h30;
    @(negedge clk);
    key_in = 64'h0;
    chk("t6_irq_lag", 64'(irq), 64'd0);
    @(negedge clk);
    chk("t6_irq_rise", 64'(irq), 64'd1);
    rd(4'h0, 64'h30, "t6_data");
    chk("t6_irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    chk("t6_irq_fall", 64'(irq), 64'd0);
`else
    wr(4'h4, 64'h1);
    rd(4'h4, 64'h0, "t6_off4");
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
